audio_sample_frontend: RTL
==========================

// Module: audio_sample_frontend
// PURPOSE
//  Conditions codec samples for ColorChordTop, replacing the ad-hoc L+R sum and [23:8] trim.
//  Captures each codec sample exactly once with a one-cycle read strobe.
//  Mixes channels per mode, applies a power-of-2 gain, and saturates to OUT_WIDTH.
//  Buffers samples in a small FIFO with a sampleReady/doingRead handshake, so bursts are not lost.
//  Reports overflow, clipping and a peak-hold level meter for LEDR.
// PARAMETERS
//  IN_WIDTH    24  codec sample width, two's complement
//  OUT_WIDTH   16  DFT input sample width
//  FIFO_DEPTH  4   sample buffer entries; power of 2, >= 2
//  METER_WIDTH 10  level meter width
//  DECAY_LOG2  16  meter decays by 1 every 2^DECAY_LOG2 clocks
// PORTS
//  clk            in   1            single clock for all logic
//  rst            in   1            asynchronous, active-low reset
//  codecReadReady in   1            codec has a sample available
//  codecRead      out  1            one-cycle acknowledge/pop to codec
//  codecLeft      in   IN_WIDTH     left sample
//  codecRight     in   IN_WIDTH     right sample
//  mixMode        in   2            mix_mode_t: LEFT=0, RIGHT=1, SUM=2, AVG=3
//  gainShift      in   3            arithmetic left shift, 0..7
//  sampleReady    out  1            FIFO non-empty; outputSample valid
//  doingRead      in   1            DFT consumes head sample this cycle
//  outputSample   out  OUT_WIDTH    FIFO head, first-word-fall-through
//  overflowCount  out  8            samples dropped on full FIFO; saturates at 255
//  clipFlag       out  1            sticky; set when any sample saturated
//  levelMeter     out  METER_WIDTH  peak-hold magnitude
// BEHAVIOUR
//  Reset (rst=0, async): FSM=IDLE, codecRead=0, FIFO empty, sampleReady=0, outputSample=0,
//   overflowCount=0, clipFlag=0, levelMeter=0, decay counter=0. A reset mid-operation discards
//   all buffered samples.
//  Capture FSM, registered outputs:
//   IDLE: codecReadReady=1 -> latch L/R/mixMode/gainShift, go to ACK.
//   ACK: codecRead=1 for exactly this cycle; processed sample pushed at end of cycle -> WAIT.
//   WAIT: stays until codecReadReady=0 -> IDLE. Prevents a double read while codec ready lags.
//  Latency: codecReadReady sampled high at edge N; codecRead high in N..N+1;
//   sampleReady high from edge N+2 if FIFO was empty.
//  Arithmetic:
//   Mix: sign-extend L and R to IN_WIDTH+1. LEFT=L, RIGHT=R, SUM=L+R, AVG=(L+R)>>>1.
//   Scale: scaled = mix <<< gainShift, width IN_WIDTH+8.
//   Trim: t = scaled >>> (IN_WIDTH+1-OUT_WIDTH).
//   Saturate: t to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1]; any saturation sets clipFlag.
//   Mode and gain changes apply from the next captured sample.
//  FIFO:
//   Pop when doingRead & sampleReady. doingRead while empty is ignored.
//   Push when full with no pop in the same cycle: sample dropped, overflowCount+1
//    (saturating); codecRead still pulses.
//   Push and pop in the same cycle while full: accepted, no drop.
//   Push and pop in the same cycle while empty: push only; the pop is ignored.
//   Pointers wrap modulo FIFO_DEPTH; count is held separately.
//  Meter:
//   mag = |pushed sample| >> (OUT_WIDTH-1-METER_WIDTH); -2^(OUT_WIDTH-1) is treated as the
//    max positive value.
//   On push: mag>levelMeter -> levelMeter=mag.
//   Otherwise, on decay-counter wrap: levelMeter-1, floored at 0. A push overrides decay
//    in the same cycle.
// STRUCTURE
//  CCHW package: typedef enum logic [1:0] mix_mode_t {MIX_LEFT, MIX_RIGHT, MIX_SUM, MIX_AVG};
//   capture FSM state enum.
//  Sub-module SampleFifo: parametrised width/depth FWFT FIFO with full/empty, async active-low reset.
//  Mix/scale/saturate and the meter stay inline.
// TESTING
//  1 SUM, gain 1, L=R=0x100000 -> one codecRead pulse; outputSample=0x2000, clipFlag=0.
//  2 AVG, gain 0, L=0x7FFFFF, R=0x800000 -> outputSample=0xFFFF (-1).
//  3 SUM, gain 7, L=R=0x400000 -> outputSample=0x7FFF, clipFlag=1 and stays 1.
//  4 doingRead held 0, 6 samples, DEPTH 4 -> 4 buffered, overflowCount=2.
//    Then pop with a simultaneous push while full -> no new drop.
//  5 codecReadReady held high 10 cycles -> exactly one codecRead pulse;
//    a second pulse only after ready drops and rises again.
//  6 rst low while FIFO holds 3 samples -> sampleReady=0, counters 0 immediately.
//    Meter 0x200, no pushes, DECAY_LOG2=4 -> decrements every 16 clocks.

Source files
------------

// File: rtl/cchw_pkg.sv
// rtl/cchw_pkg.sv - shared types for the audio sample frontend
//
// Purpose: channel mix mode and capture FSM state encodings used by
// audio_sample_frontend. No ports.
package cchw_pkg;

  typedef enum logic [1:0] {
    MIX_LEFT  = 2'd0,
    MIX_RIGHT = 2'd1,
    MIX_SUM   = 2'd2,
    MIX_AVG   = 2'd3
  } mix_mode_t;

  typedef enum logic [1:0] {
    CAP_IDLE = 2'd0,
    CAP_ACK  = 2'd1,
    CAP_WAIT = 2'd2
  } cap_state_t;

endpackage

// File: rtl/audio_sample_frontend_fifo.sv
// rtl/audio_sample_frontend_fifo.sv - first-word-fall-through sample FIFO
//
// Purpose: small FWFT buffer between codec capture and the DFT consumer.
// Ports:
//   i_clk, i_rst_n     clock, asynchronous active-low reset
//   i_push, i_data     write request and data (ignored when full unless popping)
//   i_pop              read request (ignored when empty)
//   o_data             head entry, zero while empty
//   o_full, o_empty    occupancy flags
module SampleFifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_pop;
  logic             w_push;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CNT_W'(DEPTH));
  // A pop on an empty FIFO is dropped, so a simultaneous push lands alone.
  assign w_pop   = i_pop & ~o_empty;
  // When full, a push is only accepted if the head leaves in the same cycle.
  assign w_push  = i_push & (~o_full | w_pop);
  assign o_data  = o_empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/audio_sample_frontend.sv
// rtl/audio_sample_frontend.sv - codec sample capture, mix, gain, saturate, buffer, meter
//
// Purpose: captures each codec sample once, mixes L/R, scales by 2^gainShift,
// trims and saturates to OUT_WIDTH, buffers in a FWFT FIFO and reports
// overflow, clipping and a decaying peak level.
// Ports:
//   clk, rst                      clock, asynchronous active-low reset
//   codecReadReady / codecRead    codec sample available / one-cycle acknowledge
//   codecLeft, codecRight         raw two's complement samples
//   mixMode, gainShift            mix_mode_t and left-shift amount, latched per capture
//   sampleReady, doingRead        FIFO non-empty / consumer pops head
//   outputSample                  FIFO head
//   overflowCount                 saturating count of dropped samples
//   clipFlag                      sticky saturation indicator
//   levelMeter                    peak-hold magnitude
module audio_sample_frontend
  import cchw_pkg::*;
#(
  parameter int IN_WIDTH    = 24,
  parameter int OUT_WIDTH   = 16,
  parameter int FIFO_DEPTH  = 4,
  parameter int METER_WIDTH = 10,
  parameter int DECAY_LOG2  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   codecReadReady,
  output logic                   codecRead,
  input  logic [IN_WIDTH-1:0]    codecLeft,
  input  logic [IN_WIDTH-1:0]    codecRight,
  input  logic [1:0]             mixMode,
  input  logic [2:0]             gainShift,
  output logic                   sampleReady,
  input  logic                   doingRead,
  output logic [OUT_WIDTH-1:0]   outputSample,
  output logic [7:0]             overflowCount,
  output logic                   clipFlag,
  output logic [METER_WIDTH-1:0] levelMeter
);

  localparam int MIX_W     = IN_WIDTH + 1;
  localparam int SCL_W     = IN_WIDTH + 8;
  localparam int TRIM      = IN_WIDTH + 1 - OUT_WIDTH;
  localparam int MAG_W     = OUT_WIDTH - 1;
  localparam int MAG_SHIFT = OUT_WIDTH - 1 - METER_WIDTH;

  cap_state_t r_state, w_next_state;

  logic [IN_WIDTH-1:0]    r_left, r_right;
  mix_mode_t              r_mode;
  logic [2:0]             r_gain;

  logic signed [MIX_W-1:0] w_l, w_r, w_sum, w_mix;
  logic signed [SCL_W-1:0] w_scaled, w_trim;
  logic                    w_ovf;
  logic [OUT_WIDTH-1:0]    w_sat;

  logic                   r_push_valid;
  logic [OUT_WIDTH-1:0]   r_push_data;
  logic                   r_push_clip;

  logic w_full, w_empty, w_pop, w_drop, w_accept;

  logic [MAG_W-1:0]       w_abs, w_mag;
  logic [DECAY_LOG2-1:0]  r_decay;
  logic                   w_decay_wrap;

  // ---------------- capture FSM ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= CAP_IDLE;
    else      r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      CAP_IDLE: if (codecReadReady)  w_next_state = CAP_ACK;
      CAP_ACK:                       w_next_state = CAP_WAIT;
      // Codec ready may lag our acknowledge; wait for it to drop before re-arming.
      CAP_WAIT: if (!codecReadReady) w_next_state = CAP_IDLE;
      default:                       w_next_state = CAP_IDLE;
    endcase
  end

  always_comb begin
    codecRead = (r_state == CAP_ACK);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_left  <= '0;
      r_right <= '0;
      r_mode  <= MIX_LEFT;
      r_gain  <= '0;
    end else if (r_state == CAP_IDLE && codecReadReady) begin
      r_left  <= codecLeft;
      r_right <= codecRight;
      r_mode  <= mix_mode_t'(mixMode);
      r_gain  <= gainShift;
    end
  end

  // ---------------- mix / scale / saturate ----------------
  assign w_l   = $signed({r_left[IN_WIDTH-1], r_left});
  assign w_r   = $signed({r_right[IN_WIDTH-1], r_right});
  assign w_sum = w_l + w_r;

  always_comb begin
    w_mix = w_l;
    case (r_mode)
      MIX_LEFT:  w_mix = w_l;
      MIX_RIGHT: w_mix = w_r;
      MIX_SUM:   w_mix = w_sum;
      MIX_AVG:   w_mix = w_sum >>> 1;
      default:   w_mix = w_l;
    endcase
  end

  assign w_scaled = $signed({{(SCL_W-MIX_W){w_mix[MIX_W-1]}}, w_mix}) <<< r_gain;
  assign w_trim   = w_scaled >>> TRIM;
  // In range only if every bit from the output sign bit upward agrees.
  assign w_ovf    = ~((&w_trim[SCL_W-1:OUT_WIDTH-1]) | ~(|w_trim[SCL_W-1:OUT_WIDTH-1]));
  assign w_sat    = !w_ovf ? w_trim[OUT_WIDTH-1:0] :
                    w_trim[SCL_W-1] ? {1'b1, {(OUT_WIDTH-1){1'b0}}} :
                                      {1'b0, {(OUT_WIDTH-1){1'b1}}};

  // The processed sample is registered at the end of ACK and written into the
  // FIFO one clock later, keeping the shift/saturate path off the FIFO write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_push_valid <= 1'b0;
      r_push_data  <= '0;
      r_push_clip  <= 1'b0;
    end else begin
      r_push_valid <= (r_state == CAP_ACK);
      if (r_state == CAP_ACK) begin
        r_push_data <= w_sat;
        r_push_clip <= w_ovf;
      end
    end
  end

  // ---------------- buffer ----------------
  SampleFifo #(.WIDTH(OUT_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_push  (r_push_valid),
    .i_data  (r_push_data),
    .i_pop   (doingRead),
    .o_data  (outputSample),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign sampleReady = ~w_empty;
  assign w_pop       = doingRead & ~w_empty;
  assign w_drop      = r_push_valid & w_full & ~w_pop;
  assign w_accept    = r_push_valid & ~w_drop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflowCount <= '0;
      clipFlag      <= 1'b0;
    end else begin
      if (w_drop && overflowCount != 8'hFF) overflowCount <= overflowCount + 8'd1;
      if (r_push_valid && r_push_clip)      clipFlag      <= 1'b1;
    end
  end

  // ---------------- level meter ----------------
  // Most negative code has no positive twin; report it as full scale.
  assign w_abs = !r_push_data[OUT_WIDTH-1] ? r_push_data[OUT_WIDTH-2:0] :
                 (r_push_data[OUT_WIDTH-2:0] == '0) ? {MAG_W{1'b1}} :
                 (~r_push_data[OUT_WIDTH-2:0] + MAG_W'(1));
  assign w_mag        = w_abs >> MAG_SHIFT;
  assign w_decay_wrap = &r_decay;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_decay    <= '0;
      levelMeter <= '0;
    end else begin
      r_decay <= r_decay + DECAY_LOG2'(1);
      if (w_accept) begin
        if (w_mag > {{MAG_SHIFT{1'b0}}, levelMeter}) levelMeter <= w_mag[METER_WIDTH-1:0];
      end else if (w_decay_wrap && levelMeter != '0) begin
        levelMeter <= levelMeter - METER_WIDTH'(1);
      end
    end
  end

endmodule
